// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Oversampling ratio and mid-bit sample point are fixed here so tx/rx agree.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloading with max(i_prescale,1)-1, one tick at zero.
// Advances only while clk_en is high; i_reload realigns the phase.
module uart_baud_tick #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_reload,
  output logic                      o_tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] w_reload_val;

  // A prescale of zero behaves like one: tick on every enabled cycle.
  assign w_reload_val = (i_prescale == '0) ? '0 : i_prescale - PRESCALE_WIDTH'(1);
  assign o_tick       = clk_en & ~i_reload & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= w_reload_val;
    end else if (clk_en) begin
      r_cnt <= (r_cnt == '0) ? w_reload_val : r_cnt - PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver, 16x oversampled, byte out on valid/ready with a one-entry holding register.
// A byte arriving while the holding register is still full is dropped and flagged as overrun.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_rxd,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  input  logic                      i_out_ready,
  output logic                      o_busy,
  output logic                      o_frame_error,
  output logic                      o_overrun_error
);

  localparam int              BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [3:0]      LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      MID_TICK  = 4'(MID_SAMPLE - 1);

  uart_rx_state_t        r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [3:0]            r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_error;
  logic                  r_overrun_error;
  logic                  w_rxd;
  logic                  w_tick;
  logic                  w_reload;

  assign w_rxd    = r_sync2;
  assign w_reload = (r_state == IDLE) & ~w_rxd;

  uart_baud_tick #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .i_prescale(i_prescale),
    .i_reload  (w_reload),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_tick_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_data          <= '0;
      r_valid         <= 1'b0;
      r_frame_error   <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      r_sync1         <= i_rxd;
      r_sync2         <= r_sync1;
      r_frame_error   <= 1'b0;
      r_overrun_error <= 1'b0;
      if (r_valid && i_out_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          if (!w_rxd) r_state <= START;
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == MID_TICK) begin
              // Line back high at mid start bit means it was only a glitch.
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rxd ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == LAST_TICK) begin
              r_shift <= {w_rxd, r_shift[DATA_WIDTH-1:1]};
              if (r_bit_cnt == LAST_BIT) r_state <= STOP;
              else                       r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == LAST_TICK) begin
              if (w_rxd) begin
                r_state <= IDLE;
                if (!r_valid || i_out_ready) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end else begin
                  r_overrun_error <= 1'b1;
                end
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          if (w_rxd) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data          = r_data;
  assign o_valid         = r_valid;
  assign o_busy          = (r_state != IDLE);
  assign o_frame_error   = r_frame_error;
  assign o_overrun_error = r_overrun_error;

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
UART receiver that sits directly upstream of the bios command parser. It converts the asynchronous serial RX line into bytes on a valid/ready stream that drives the parser's byte input. Features: 16x oversampling, false-start rejection, framing and overrun detection, and a one-entry output holding register.

Parameters:
DATA_WIDTH, 8, data bits per frame (8N1 format, LSB first)
PRESCALE_WIDTH, 16, width of the runtime prescale input

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
clk_en  input  1  gates oversample-tick generation only; the handshake is unaffected
i_prescale  input  PRESCALE_WIDTH  clk cycles per oversample tick (bit time = 16*i_prescale); 0 is treated as 1
i_rxd  input  1  asynchronous serial line, idle high
o_data  output  DATA_WIDTH  received byte
o_valid  output  1  o_data holds an unconsumed byte
i_out_ready  input  1  consumer accepts the byte
o_busy  output  1  a frame is in progress (state != IDLE)
o_frame_error  output  1  one-cycle pulse: stop bit sampled low
o_overrun_error  output  1  one-cycle pulse: new byte dropped because the holding register was full

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high. Reset overrides everything.
- Reset values: o_data=0, o_valid=0, o_busy=0, o_frame_error=0, o_overrun_error=0. Both synchroniser flops reset to 1. State=IDLE. All counters=0.
- Input synchroniser: i_rxd passes through 2 flops; "rxd" below means the synchronised value.
- Tick generator: down-counter reloads with max(i_prescale,1)-1 and emits a 1-cycle tick at 0.
  - Advances only when clk_en=1.
  - Is forced to reload when leaving IDLE, so phase aligns to the start edge.
- Per-frame counters:
  - tick_cnt: 4 bits, counts oversample ticks within a bit.
  - bit_cnt: counts data bits, 0..DATA_WIDTH-1.
  - shift register: DATA_WIDTH bits, shifts right, new bit enters the MSB.
- States:
  - IDLE: rxd=0 -> START; tick_cnt=0.
  - START: on the 8th tick (mid-bit), sample rxd.
    - rxd=1: glitch -> IDLE, no flags.
    - rxd=0: -> DATA; tick_cnt=0, bit_cnt=0.
  - DATA: every 16th tick, shift in rxd.
    - After the bit with bit_cnt=DATA_WIDTH-1 -> STOP.
  - STOP: on the 16th tick, sample rxd.
    - rxd=1: deliver the byte, -> IDLE.
    - rxd=0: pulse o_frame_error, discard the byte, -> BREAK.
  - BREAK: wait for rxd=1, then -> IDLE. This prevents a held-low line from retriggering frames; a long break yields exactly one frame_error.
- Delivery, in the cycle after the stop-bit sample:
  - If o_valid=0, or o_valid=1 with i_out_ready=1 in the same cycle: load o_data, set o_valid=1.
  - Otherwise: keep the old o_data, pulse o_overrun_error, drop the new byte.
- Handshake:
  - Transfer occurs when o_valid & i_out_ready; o_valid clears the next cycle unless a new byte loads in that same cycle.
  - o_data is stable while o_valid=1.
  - o_valid does not depend combinationally on i_out_ready.
- Latency: falling edge on i_rxd -> o_valid is 2 (sync) + (8+16*DATA_WIDTH+16) ticks + 1 cycle. With DATA_WIDTH=8 this is 152 ticks.
- Reset mid-frame: the partial frame is discarded, state=IDLE. A line still low after reset is taken as a start edge; the caller must hold the line idle.
- A change to i_prescale mid-frame takes effect at the next counter reload; no other guarantee.

Decomposition:
- Package uart_pkg holds:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - localparam OVERSAMPLE=16
  - localparam MID_SAMPLE=8
- Sub-module uart_baud_tick holds the prescale down-counter and clk_en gating. It has inputs clk, rst, clk_en, i_prescale, i_reload and output o_tick. uart_baud_tick is reusable by a future uart_tx_stream.

Test Plan:
- prescale=1, i_out_ready=1, send 0xA5 -> one o_valid with o_data=0xA5, 155±1 clk after the falling edge; no error pulses.
- Low glitch of 4 clk on i_rxd -> no o_valid, o_busy returns to 0 within 9 ticks, no flags.
- Frame 0x3C with stop bit driven 0, then line held low for 40 bit times, then high, then send 0x3C correctly -> exactly one o_frame_error pulse, then o_data=0x3C valid.
- i_out_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, one o_overrun_error pulse; raise i_out_ready -> 0x11 transfers, 0x22 is never presented.
- i_out_ready=1, back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three transfers in order, no flags.
- Assert rst for 1 cycle during DATA bit 3 of a frame -> all outputs at reset values, no byte delivered; the next clean 0x7E frame is received correctly.
